uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single board UART_TX pin between two serial transmitters in clk_sys: the MIDI-out UART (src 0) and the WiFi/ESP UART (src 1).
- Changing the user select never truncates a frame: the switch is deferred until the current source's line has been idle long enough, then a high guard gap is inserted before the new source is connected.
- Sits between the core's serial outputs and the UART_TX output register in the top level; it replaces the plain select mux.

Parameters:
- IDLE_CYC, 11000: consecutive high cycles on the current source that count as "line idle" (about 12 MIDI bit-times at 28.375 MHz).
- GUARD_CYC, 2000: cycles the output is forced high after a switch, before the new source is connected.
- MAX_DRAIN_CYC, 60000: upper bound on time spent waiting for idle; on expiry the switch is forced.
- CW, 16: width of the internal cycle counters; must hold the largest of the three cycle parameters.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- sel, in, 1: requested source (0 = MIDI, 1 = WiFi); level, may change at any time.
- tx_midi, in, 1: MIDI UART serial out, idle high.
- tx_esp, in, 1: ESP UART serial out, idle high.
- uart_tx, out, 1: arbitrated serial line, registered.
- cur_src, out, 1: source currently connected to uart_tx.
- switching, out, 1: high while a source change is pending (DRAIN or GUARD).
- forced, out, 1: one-cycle pulse when a switch is forced by MAX_DRAIN_CYC.
- sof, out, 1: one-cycle pulse on each high-to-low transition of the connected source while ACTIVE (start-bit or activity indicator).

Behaviour:
- Reset (synchronous, active-high; clock clk_sys): state = ACTIVE, cur_src = sel sampled in the reset cycle, uart_tx = 1, switching = 0, forced = 0, sof = 0, idle_cnt = 0, guard_cnt = 0, drain_cnt = 0.
- Reset asserted mid-switch aborts the switch; no guard gap is produced.
- Let line = cur_src ? tx_esp : tx_midi.
- Idle tracking, every cycle:
  - line = 0 sets idle_cnt to 0.
  - Otherwise idle_cnt increments, saturating at IDLE_CYC.
  - idle_ok = (idle_cnt == IDLE_CYC).
- State ACTIVE:
  - uart_tx <= line, so latency from source to pin is 1 cycle.
  - If sel != cur_src, go to DRAIN and clear drain_cnt.
  - sof pulses the cycle after line goes 1 to 0. Edge detection uses the previous line value, which resets to 1.
- State DRAIN:
  - uart_tx <= line; the frame in flight completes untouched.
  - drain_cnt increments each cycle.
  - Transitions, in priority order:
    - sel == cur_src: back to ACTIVE (request withdrawn, no gap).
    - idle_ok: go to GUARD, set guard_cnt = 0, output high.
    - drain_cnt == MAX_DRAIN_CYC - 1: go to GUARD and pulse forced for 1 cycle.
- State GUARD:
  - uart_tx <= 1.
  - guard_cnt increments.
  - When guard_cnt == GUARD_CYC - 1: cur_src <= sel (the value at that cycle), clear idle_cnt, go to ACTIVE.
  - sel toggling during GUARD does not restart the guard; only its final value matters.
  - If the final sel equals the old cur_src, the line still had a clean gap. That is legal and no further switch follows.
- switching = (state != ACTIVE), registered together with state.
- Sources are same-domain, so no synchronisers are used.
- A source driving low continuously (break) holds the switch for at most MAX_DRAIN_CYC cycles.
- The non-selected source is ignored entirely in every state.

Test Plan:
- Bench parameters: IDLE_CYC = 20, GUARD_CYC = 8, MAX_DRAIN_CYC = 100.
- Reset with sel = 1, tx_esp toggling -> cur_src = 1; uart_tx follows tx_esp delayed by 1 cycle; uart_tx = 1 during reset.
- sel 0 to 1 while tx_midi is mid-frame (low 5 cycles, then high) -> uart_tx keeps following tx_midi; switching = 1; 20 high cycles after the last low, uart_tx is forced high for 8 cycles; then cur_src = 1 and uart_tx follows tx_esp; switching drops in that cycle.
- sel 0 to 1, then back to 0 after 10 cycles of DRAIN -> state returns to ACTIVE the next cycle; no guard gap; cur_src stays 0; forced never pulses.
- tx_midi held low permanently, sel to 1 -> forced pulses exactly once, 100 cycles after DRAIN entry; 8-cycle high gap; cur_src = 1.
- sel toggles 1, 0, 1 during GUARD -> guard length remains 8 cycles; final cur_src = 1.
- sof check: 3 falling edges on the connected source produce 3 one-cycle sof pulses; edges on the unconnected source produce none; reset asserted in GUARD returns to ACTIVE with uart_tx = 1.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the two UART sources, the user select and the arbitrated TX pin.
interface uart_tx_arbiter_if;
  logic sel;
  logic tx_midi;
  logic tx_esp;
  logic uart_tx;
  logic cur_src;
  logic switching;
  logic forced;
  logic sof;

  modport master (
    output sel, tx_midi, tx_esp,
    input  uart_tx, cur_src, switching, forced, sof
  );

  modport slave (
    input  sel, tx_midi, tx_esp,
    output uart_tx, cur_src, switching, forced, sof
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Glitch-free UART_TX source arbiter: defers a select change until the current line is idle
// (or a drain timeout expires), then holds the pin high for a guard gap before reconnecting.
module uart_tx_arbiter #(
  parameter int unsigned IDLE_CYC      = 11000,
  parameter int unsigned GUARD_CYC     = 2000,
  parameter int unsigned MAX_DRAIN_CYC = 60000,
  parameter int unsigned CW            = 16
) (
  input logic              clk_sys,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StActive, StDrain, StGuard} state_e;

  localparam logic [CW-1:0] IdleMax   = CW'(IDLE_CYC);
  localparam logic [CW-1:0] GuardLast = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] DrainLast = CW'(MAX_DRAIN_CYC - 1);

  state_e        state_q, state_d;
  logic          cur_src_q, cur_src_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic [CW-1:0] guard_cnt_q, guard_cnt_d;
  logic          uart_tx_q, uart_tx_d;
  logic          forced_q, forced_d;
  logic          sof_q, sof_d;
  logic          line_prev_q;
  logic          switching_q;
  logic          line;
  logic          idle_ok;

  assign line    = cur_src_q ? bus.tx_esp : bus.tx_midi;
  assign idle_ok = (idle_cnt_q == IdleMax);

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    drain_cnt_d = drain_cnt_q;
    guard_cnt_d = guard_cnt_q;
    uart_tx_d   = line;
    forced_d    = 1'b0;
    sof_d       = 1'b0;
    if (!line) begin
      idle_cnt_d = '0;
    end else if (idle_ok) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + CW'(1);
    end

    case (state_q)
      StActive: begin
        sof_d = line_prev_q & ~line;
        if (bus.sel != cur_src_q) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + CW'(1);
        if (bus.sel == cur_src_q) begin
          state_d = StActive;
        end else if (idle_ok) begin
          state_d     = StGuard;
          guard_cnt_d = '0;
        end else if (drain_cnt_q == DrainLast) begin
          // Source stuck low (break): give up waiting and switch anyway.
          state_d     = StGuard;
          guard_cnt_d = '0;
          forced_d    = 1'b1;
        end
      end
      StGuard: begin
        uart_tx_d   = 1'b1;
        guard_cnt_d = guard_cnt_q + CW'(1);
        if (guard_cnt_q == GuardLast) begin
          cur_src_d  = bus.sel;
          idle_cnt_d = '0;
          state_d    = StActive;
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StActive;
      cur_src_q   <= bus.sel;
      idle_cnt_q  <= '0;
      drain_cnt_q <= '0;
      guard_cnt_q <= '0;
      uart_tx_q   <= 1'b1;
      forced_q    <= 1'b0;
      sof_q       <= 1'b0;
      line_prev_q <= 1'b1;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      idle_cnt_q  <= idle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      uart_tx_q   <= uart_tx_d;
      forced_q    <= forced_d;
      sof_q       <= sof_d;
      line_prev_q <= line;
      switching_q <= (state_d != StActive);
    end
  end

  assign bus.uart_tx   = uart_tx_q;
  assign bus.cur_src   = cur_src_q;
  assign bus.switching = switching_q;
  assign bus.forced    = forced_q;
  assign bus.sof       = sof_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with IDLE_CYC=20, GUARD_CYC=8, MAX_DRAIN_CYC=100.
module tb_uart_tx_arbiter;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   n_pulse;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .IDLE_CYC      (20),
    .GUARD_CYC     (8),
    .MAX_DRAIN_CYC (100),
    .CW            (16)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input logic ux, input logic cs,
                         input logic sw, input logic fo);
    chk($sformatf("%s c%0d uart_tx", tag, c), bus.uart_tx, ux);
    chk($sformatf("%s c%0d cur_src", tag, c), bus.cur_src, cs);
    chk($sformatf("%s c%0d switching", tag, c), bus.switching, sw);
    chk($sformatf("%s c%0d forced", tag, c), bus.forced, fo);
  endtask

  task automatic apply_reset(input logic s);
    reset       = 1'b1;
    bus.sel     = s;
    bus.tx_midi = 1'b1;
    bus.tx_esp  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  esp_pat;
    logic [11:0] sof_pat;
    esp_pat = 8'h96;
    sof_pat = 12'hF69;

    // Reset with sel=1 while tx_esp toggles: pin stays high, ESP selected.
    reset       = 1'b1;
    bus.sel     = 1'b1;
    bus.tx_midi = 1'b1;
    bus.tx_esp  = 1'b0;
    tick();
    chk_out("rst", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst sof", bus.sof, 1'b0);
    bus.tx_esp = 1'b1;
    tick();
    bus.tx_esp = 1'b0;
    tick();
    chk("rst hold uart_tx", bus.uart_tx, 1'b1);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus.tx_esp  = esp_pat[c-1];
      bus.tx_midi = ~esp_pat[c-1];
      tick();
      chk_out("follow", c, esp_pat[c-1], 1'b1, 1'b0, 1'b0);
    end

    // Switch request mid-frame: wait for idle, guard gap, then reconnect.
    apply_reset(1'b0);
    for (int c = 1; c <= 35; c++) begin
      bus.tx_midi = (c <= 5) ? 1'b0 : 1'b1;
      bus.sel     = (c >= 3);
      bus.tx_esp  = (c >= 6) ? 1'b0 : 1'b1;
      tick();
      chk_out("drain", c, (c <= 5 || c == 35) ? 1'b0 : 1'b1, c >= 34, c >= 3 && c <= 33, 1'b0);
    end

    // Request withdrawn during drain: no gap, no switch.
    apply_reset(1'b0);
    for (int c = 1; c <= 30; c++) begin
      bus.sel     = (c <= 10);
      bus.tx_midi = (c % 3 != 0);
      bus.tx_esp  = 1'b0;
      tick();
      chk_out("withdraw", c, (c % 3 != 0), 1'b0, c <= 10, 1'b0);
    end

    // Source stuck low: switch forced after the drain timeout.
    apply_reset(1'b0);
    n_pulse = 0;
    for (int c = 1; c <= 112; c++) begin
      bus.sel     = 1'b1;
      bus.tx_midi = 1'b0;
      bus.tx_esp  = 1'b0;
      tick();
      if (bus.forced) n_pulse++;
      chk_out("force", c, (c >= 102 && c <= 109), c >= 109, c <= 108, c == 101);
    end
    n_vec++;
    assert (n_pulse === 1) else begin
      n_miss++;
      $error("FAIL force pulse count: observed %0d expected 1", n_pulse);
    end

    // sel toggling inside the guard window does not stretch it.
    apply_reset(1'b0);
    for (int c = 1; c <= 32; c++) begin
      bus.sel     = !(c == 23 || c == 24);
      bus.tx_midi = 1'b1;
      bus.tx_esp  = 1'b0;
      tick();
      chk_out("guard_sel", c, c <= 29, c >= 29, c <= 28, 1'b0);
    end

    // Start-of-frame pulses on connected source only, then reset in the middle of a guard.
    apply_reset(1'b0);
    n_pulse = 0;
    for (int c = 1; c <= 33; c++) begin
      reset       = (c == 31);
      bus.sel     = (c >= 13);
      bus.tx_midi = (c <= 12) ? sof_pat[c-1] : 1'b1;
      bus.tx_esp  = (c <= 12) ? c[0] : (c >= 31 ? 1'b0 : 1'b1);
      tick();
      chk_out("sof", c, (c <= 12) ? sof_pat[c-1] : (c <= 31), c >= 31, c >= 13 && c <= 30,
              1'b0);
      if (c <= 31) begin
        if (bus.sof) n_pulse++;
        chk($sformatf("sof c%0d sof", c), bus.sof, (c == 2 || c == 5 || c == 8));
      end
    end
    reset = 1'b0;
    n_vec++;
    assert (n_pulse === 3) else begin
      n_miss++;
      $error("FAIL sof pulse count: observed %0d expected 3", n_pulse);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
